// File: rtl/cv32e40x_pkg.sv
// Shared types for the illegal-instruction recorder: the slice of the EX/WB
// pipeline register it observes and the record format it stores.
package cv32e40x_pkg;

  localparam int unsigned REC_PC_W     = 32;
  localparam int unsigned REC_HARTID_W = 4;
  localparam int unsigned REC_CYCLE_W  = 32;

  // Fields of the EX/WB pipeline register consumed by the recorder
  typedef struct packed {
    logic                instr_valid;
    logic                illegal_insn;
    logic [REC_PC_W-1:0] pc;
  } ex_wb_pipe_t;

  // One recorded illegal-instruction event
  typedef struct packed {
    logic [REC_PC_W-1:0]     pc;
    logic [REC_HARTID_W-1:0] hartid;
    logic [REC_CYCLE_W-1:0]  cycle;
    logic                    ovf;
  } illegal_rec_t;

  // Assemble a record from its captured fields
  function automatic illegal_rec_t build_rec(
    input logic [REC_PC_W-1:0]     pc,
    input logic [REC_HARTID_W-1:0] hartid,
    input logic [REC_CYCLE_W-1:0]  cycle,
    input logic                    ovf
  );
    illegal_rec_t rec;
    rec.pc     = pc;
    rec.hartid = hartid;
    rec.cycle  = cycle;
    rec.ovf    = ovf;
    return rec;
  endfunction

endpackage

// File: rtl/cv32e40x_illegal_insn_recorder_if.sv
// Read-side handshake of the illegal-instruction recorder: the producer
// (master) presents a record with valid, the consumer (slave) answers ready.
interface cv32e40x_illegal_insn_recorder_if;

  logic                       rd_valid;
  logic                       rd_ready;
  cv32e40x_pkg::illegal_rec_t rd_rec;

  modport master (
    output rd_valid,
    output rd_rec,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_rec,
    output rd_ready
  );

endinterface

// File: rtl/cv32e40x_illegal_rec_fifo.sv
// Small synchronous FIFO holding recorded events. Pointers carry one extra
// wrap bit so that full and empty are distinguishable with DEPTH a power of 2.
// Storage is not reset; the head is always read straight from the array.
module cv32e40x_illegal_rec_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic push_i,
  input  T     push_data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output T     pop_data_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] wptr_q;
  logic [AW:0] wptr_d;
  logic [AW:0] rptr_q;
  logic [AW:0] rptr_d;
  logic        do_push_s;
  logic        do_pop_s;
  T            mem_q [DEPTH];

  assign empty_o    = (wptr_q == rptr_q);
  assign full_o     = (wptr_q[AW] != rptr_q[AW]) &&
                      (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop_data_o = mem_q[rptr_q[AW-1:0]];

  // Decide which pointer moves; flush wins, and a pop frees a slot for a push even when full
  always_comb begin
    do_pop_s  = 1'b0;
    do_push_s = 1'b0;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      do_pop_s  = pop_i && !empty_o;
      do_push_s = push_i && (!full_o || do_pop_s);
      if (do_pop_s) begin
        rptr_d = rptr_q + PTR_ONE;
      end else begin
        rptr_d = rptr_q;
      end
      if (do_push_s) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end
    end
  end

  // Pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/cv32e40x_illegal_insn_recorder.sv
// Records illegal instructions retiring from WB into a small FIFO, stamped
// with PC, hart ID and a free-running cycle count. Events arriving while the
// FIFO is full are counted and flagged on the next record that gets in.
module cv32e40x_illegal_insn_recorder
  import cv32e40x_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  ex_wb_pipe_t           ex_wb_pipe_i,
  input  logic                  wb_valid_i,
  input  logic [31:0]           mhartid_i,
  input  logic                  clear_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output illegal_rec_t          rd_rec_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  localparam logic [DROP_CNT_W-1:0] DROP_ONE = DROP_CNT_W'(1);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};

  logic                  capture_s;
  logic                  pop_s;
  logic                  accept_s;
  logic                  drop_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  illegal_rec_t          push_rec_s;

  logic [31:0]           cycle_q;
  logic [31:0]           cycle_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q;
  logic [DROP_CNT_W-1:0] drop_cnt_d;
  logic                  pending_ovf_q;
  logic                  pending_ovf_d;

  // Only the low hart-ID bits are kept in a record
  logic                  unused_hartid_s;
  assign unused_hartid_s = ^mhartid_i[31:REC_HARTID_W];

  assign rd_valid_o = !fifo_empty_s;
  assign drop_cnt_o = drop_cnt_q;
  assign push_rec_s = build_rec(ex_wb_pipe_i.pc, mhartid_i[REC_HARTID_W-1:0],
                                cycle_q, pending_ovf_q);

  // Classify this cycle's event: accepted into the FIFO, dropped, or ignored
  always_comb begin
    capture_s = wb_valid_i && ex_wb_pipe_i.instr_valid && ex_wb_pipe_i.illegal_insn;
    pop_s     = rd_valid_o && rd_ready_i;
    accept_s  = 1'b0;
    drop_s    = 1'b0;
    if (clear_i) begin
      accept_s = 1'b0;
      drop_s   = 1'b0;
    end else if (capture_s) begin
      if (!fifo_full_s || pop_s) begin
        accept_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      accept_s = 1'b0;
      drop_s   = 1'b0;
    end
  end

  // Next-state for cycle counter, saturating drop counter and pending overflow flag
  always_comb begin
    cycle_d       = cycle_q + 32'd1;
    drop_cnt_d    = drop_cnt_q;
    pending_ovf_d = pending_ovf_q;
    if (clear_i) begin
      drop_cnt_d    = '0;
      pending_ovf_d = 1'b0;
    end else if (drop_s) begin
      pending_ovf_d = 1'b1;
      if (drop_cnt_q != DROP_MAX) begin
        drop_cnt_d = drop_cnt_q + DROP_ONE;
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end else if (accept_s) begin
      pending_ovf_d = 1'b0;
    end else begin
      pending_ovf_d = pending_ovf_q;
    end
  end

  // Recorder state registers; the cycle counter ignores clear_i
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q       <= 32'd0;
      drop_cnt_q    <= '0;
      pending_ovf_q <= 1'b0;
    end else begin
      cycle_q       <= cycle_d;
      drop_cnt_q    <= drop_cnt_d;
      pending_ovf_q <= pending_ovf_d;
    end
  end

  cv32e40x_illegal_rec_fifo #(
    .DEPTH (DEPTH),
    .T     (illegal_rec_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (clear_i),
    .push_i      (accept_s),
    .push_data_i (push_rec_s),
    .pop_i       (pop_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .pop_data_o  (rd_rec_o)
  );

endmodule

// File: tb/tb_cv32e40x_illegal_insn_recorder.sv
// Bench for the illegal-instruction recorder: directed scenarios followed by
// random traffic, checked by a queue-based reference model and a monitor.
module tb_cv32e40x_illegal_insn_recorder;
  import cv32e40x_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  ex_wb_pipe_t pipe;
  logic        wb_valid;
  logic [31:0] hart;
  logic        clear;
  logic [15:0] drop_cnt;
  logic [1:0]  drop_cnt_sat;
  logic        sat_valid;
  illegal_rec_t sat_rec;

  cv32e40x_illegal_insn_recorder_if rd_if ();

  always #5 clk = ~clk;

  cv32e40x_illegal_insn_recorder #(.DEPTH(DEPTH), .DROP_CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_wb_pipe_i (pipe),
    .wb_valid_i   (wb_valid),
    .mhartid_i    (hart),
    .clear_i      (clear),
    .rd_valid_o   (rd_if.rd_valid),
    .rd_ready_i   (rd_if.rd_ready),
    .rd_rec_o     (rd_if.rd_rec),
    .drop_cnt_o   (drop_cnt)
  );

  cv32e40x_illegal_insn_recorder #(.DEPTH(DEPTH), .DROP_CNT_W(2)) u_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_wb_pipe_i (pipe),
    .wb_valid_i   (wb_valid),
    .mhartid_i    (hart),
    .clear_i      (clear),
    .rd_valid_o   (sat_valid),
    .rd_ready_i   (rd_if.rd_ready),
    .rd_rec_o     (sat_rec),
    .drop_cnt_o   (drop_cnt_sat)
  );

  int           n_pass = 0;
  int           n_total = 0;
  int           dut_pops = 0;
  illegal_rec_t exp_q[$];
  illegal_rec_t mq[$];
  int           m_drops;
  logic         m_pend;
  logic [31:0]  m_cyc;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_pend  = 1'b0;
    m_drops = 0;
    m_cyc   = 32'd0;
  endtask

  // Reference behaviour of one clock edge
  task automatic model_edge(input logic wb, iv, ill, input logic [31:0] pc, hid,
                            input logic rdy, clr);
    illegal_rec_t r;
    bit full, pop;
    if (clr) begin
      mq.delete();
      exp_q.delete();
      m_pend  = 1'b0;
      m_drops = 0;
    end else begin
      full = (mq.size() == DEPTH);
      pop  = (mq.size() != 0) && rdy;
      if (pop) void'(mq.pop_front());
      if (wb && iv && ill) begin
        if (!full || pop) begin
          r.pc = pc; r.hartid = hid[3:0]; r.cycle = m_cyc; r.ovf = m_pend;
          mq.push_back(r);
          exp_q.push_back(r);
          m_pend = 1'b0;
        end else begin
          m_drops++;
          m_pend = 1'b1;
        end
      end
    end
    m_cyc = m_cyc + 32'd1;
  endtask

  task automatic step(input logic wb, iv, ill, input logic [31:0] pc, hid,
                      input logic rdy, clr);
    int e16, e2;
    wb_valid          = wb;
    pipe.instr_valid  = iv;
    pipe.illegal_insn = ill;
    pipe.pc           = pc;
    hart              = hid;
    rd_if.rd_ready    = rdy;
    clear             = clr;
    @(posedge clk);
    #1;
    model_edge(wb, iv, ill, pc, hid, rdy, clr);
    e16 = (m_drops > 65535) ? 65535 : m_drops;
    e2  = (m_drops > 3) ? 3 : m_drops;
    chk("rd_valid", 96'(rd_if.rd_valid), 96'(mq.size() != 0));
    chk("drop_cnt", 96'(drop_cnt), 96'(e16));
    chk("drop_cnt_w2", 96'(drop_cnt_sat), 96'(e2));
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, rdy, 1'b0);
  endtask

  task automatic event_(input logic [31:0] pc, input logic rdy);
    step(1'b1, 1'b1, 1'b1, pc, 32'h5, rdy, 1'b0);
  endtask

  task automatic do_clear();
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  // Monitor: compare the presented head with the scoreboard, retire on handshake
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rd_if.rd_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_entry", 96'(rd_if.rd_valid), 96'd0);
        end else begin
          chk("head_rec", 96'(rd_if.rd_rec), 96'(exp_q[0]));
          if (rd_if.rd_ready) begin
            void'(exp_q.pop_front());
            dut_pops++;
          end
        end
      end
    end
  end

  initial begin
    int p0;
    illegal_rec_t want;
    rst_n = 1'b0;
    wb_valid = 1'b0; pipe = '0; hart = 32'h0; clear = 1'b0; rd_if.rd_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 96'(rd_if.rd_valid), 96'd0);
    chk("reset_drop", 96'(drop_cnt), 96'd0);
    rst_n = 1'b1;

    // Single event at cycle 10 into an empty FIFO
    while (m_cyc != 32'd10) idle(1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h0000_1004, 32'd3, 1'b1, 1'b0);
    want.pc = 32'h1004; want.hartid = 4'd3; want.cycle = 32'd10; want.ovf = 1'b0;
    chk("single_valid", 96'(rd_if.rd_valid), 96'd1);
    chk("single_rec", 96'(rd_if.rd_rec), 96'(want));
    idle(1'b1);
    chk("single_empty", 96'(rd_if.rd_valid), 96'd0);

    // Stalled WB: only the advancing cycle captures
    do_clear();
    p0 = dut_pops;
    for (int i = 0; i < 5; i++) step(i == 2, 1'b1, 1'b1, 32'h2000 + 32'(i * 4), 32'h1, 1'b0, 1'b0);
    repeat (6) idle(1'b1);
    chk("stall_entries", 96'(dut_pops - p0), 96'd1);

    // Overflow: 6 events into DEPTH=4
    do_clear();
    for (int i = 0; i < 6; i++) event_(32'h3000 + 32'(i * 4), 1'b0);
    chk("ovf_drops", 96'(drop_cnt), 96'd2);
    p0 = dut_pops;
    repeat (6) idle(1'b1);
    chk("ovf_drained", 96'(dut_pops - p0), 96'd4);
    event_(32'h3700, 1'b0);
    chk("ovf_7th", 96'(rd_if.rd_rec.ovf), 96'd1);
    idle(1'b1);
    event_(32'h3800, 1'b0);
    chk("ovf_8th", 96'(rd_if.rd_rec.ovf), 96'd0);
    idle(1'b1);

    // Full with simultaneous push and pop
    do_clear();
    for (int i = 0; i < 4; i++) event_(32'h4000 + 32'(i * 4), 1'b0);
    event_(32'h4100, 1'b1);
    chk("fullpp_drop", 96'(drop_cnt), 96'd0);
    p0 = dut_pops;
    repeat (6) idle(1'b1);
    chk("fullpp_count", 96'(dut_pops - p0), 96'd4);

    // Clear has priority over event and pop
    do_clear();
    for (int i = 0; i < 2; i++) event_(32'h5000 + 32'(i * 4), 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h5100, 32'h2, 1'b1, 1'b1);
    chk("clear_valid", 96'(rd_if.rd_valid), 96'd0);
    chk("clear_drop", 96'(drop_cnt), 96'd0);
    repeat (3) idle(1'b1);
    chk("clear_stays_empty", 96'(rd_if.rd_valid), 96'd0);

    // Drop counter saturation on the 2-bit instance
    do_clear();
    for (int i = 0; i < 9; i++) event_(32'h6000 + 32'(i * 4), 1'b0);
    chk("sat_w16", 96'(drop_cnt), 96'd5);
    chk("sat_w2", 96'(drop_cnt_sat), 96'd3);

    // Asynchronous reset mid-operation
    do_clear();
    for (int i = 0; i < 3; i++) event_(32'h7000 + 32'(i * 4), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 96'(rd_if.rd_valid), 96'd0);
    chk("async_rst_drop", 96'(drop_cnt), 96'd0);
    model_reset();
    wb_valid = 1'b0; pipe = '0; clear = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    event_(32'h7100, 1'b0);
    chk("post_rst_valid", 96'(rd_if.rd_valid), 96'd1);
    chk("post_rst_cycle", 96'(rd_if.rd_rec.cycle), 96'd0);
    idle(1'b1);

    // Random traffic with varying consumer readiness
    for (int ph = 0; ph < 15; ph++) begin
      int pct;
      case (ph % 3)
        0:       pct = 15;
        1:       pct = 55;
        default: pct = 95;
      endcase
      for (int i = 0; i < 100; i++) begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             $urandom() & 32'hFFFF_FFFC, $urandom(), $urandom_range(0, 99) < pct,
             $urandom_range(0, 199) == 0);
      end
    end

    repeat (8) idle(1'b1);
    chk("scoreboard_drained", 96'(exp_q.size()), 96'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cv32e40x_illegal_insn_recorder.md
CV32E40X_ILLEGAL_INSN_RECORDER -- requirements
Module: cv32e40x_illegal_insn_recorder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries; legal values are powers of 2, minimum 2.
REQ-002 SHALL have parameter DROP_CNT_W, default 16, meaning width of the saturating drop counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port ex_wb_pipe_i, input, ex_wb_pipe_t: EX/WB pipeline register; uses fields instr_valid, illegal_insn and pc.
REQ-006 SHALL have port wb_valid_i, input, 1 bit: WB stage retires/advances this cycle, one pulse per instruction.
REQ-007 SHALL have port mhartid_i, input, 32 bits: hart ID; bits [3:0] are recorded.
REQ-008 SHALL have port clear_i, input, 1 bit: synchronous flush of FIFO, drop counter and overflow flag.
REQ-009 SHALL have port rd_valid_o, output, 1 bit: head entry available.
REQ-010 SHALL have port rd_ready_i, input, 1 bit: consumer accepts head.
REQ-011 SHALL have port rd_rec_o, output, illegal_rec_t: head entry {pc[31:0], hartid[3:0], cycle[31:0], ovf}.
REQ-012 SHALL have port drop_cnt_o, output, DROP_CNT_W bits: events lost because the FIFO was full.

Function
REQ-013 Capture event SHALL be wb_valid_i && ex_wb_pipe_i.instr_valid && ex_wb_pipe_i.illegal_insn; stalled (non-advancing) cycles SHALL NOT capture.
REQ-014 A free-running 32-bit cycle counter SHALL increment every cycle, wrap 0xFFFFFFFF->0, and be unaffected by clear_i.
REQ-015 A captured entry SHALL store pc, mhartid_i[3:0] and the counter value of the capture cycle.
REQ-016 Latency: an event captured in cycle N into an empty FIFO SHALL give rd_valid_o=1 in cycle N+1 (registered output, no bypass).
REQ-017 Pop SHALL occur when rd_valid_o && rd_ready_i; rd_rec_o SHALL be held stable while rd_valid_o && !rd_ready_i.
REQ-018 Occupancy states: EMPTY (rd_valid_o=0), PARTIAL, and FULL (DEPTH entries); pointers SHALL wrap modulo DEPTH, and an extra wrap bit SHALL distinguish full from empty.
REQ-019 Push and pop in the same cycle SHALL both take effect at any occupancy, including FULL: the freed slot accepts the push and no drop occurs.
REQ-020 Capture while FULL without a pop SHALL be dropped, increment drop_cnt_o (saturating at all-ones), and set pending_ovf.
REQ-021 The next accepted entry SHALL have ovf=pending_ovf, and accepting it SHALL clear pending_ovf.
REQ-022 clear_i SHALL take priority over push/pop in the same cycle: next cycle the FIFO is EMPTY, drop_cnt_o=0 and pending_ovf=0; an event coincident with clear_i is discarded and not counted.
REQ-023 rd_rec_o SHALL be don't-care when rd_valid_o=0, but SHALL be driven, never X-propagating, from the storage array.

Reset
REQ-024 On rst_n low, rd_valid_o=0, drop_cnt_o=0, pending_ovf=0, pointers=0 and cycle counter=0, with effect immediate and asynchronous.
REQ-025 Storage array contents SHALL NOT require reset.
REQ-026 Reset asserted mid-operation SHALL discard all entries; the first capture after deassertion behaves as into an EMPTY FIFO.

Structure
REQ-027 illegal_rec_t SHALL be declared in cv32e40x_pkg.
REQ-028 The FIFO SHALL be the sub-module cv32e40x_illegal_rec_fifo, with DEPTH and element type as parameters and push/pop/full/empty/flush ports; capture, counter, drop and overflow logic SHALL reside in the top.
REQ-029 The block SHALL be synthesizable with no simulation-only constructs.

Verification
REQ-030 Single event: pc=0x0000_1004, hartid=3, cycle=10, rd_ready_i=1 -> rd_valid_o=1 at cycle 11 with {0x1004,3,10,ovf=0}, popped, then EMPTY.
REQ-031 Stall: instr_valid=illegal_insn=1 held 5 cycles with wb_valid_i=1 in only one of them -> exactly one entry.
REQ-032 Overflow: DEPTH=4, rd_ready_i=0, 6 events -> 4 entries, drop_cnt_o=2; drain -> entries 1-4 ovf=0; a 7th event -> ovf=1; an 8th event -> ovf=0.
REQ-033 Full push+pop: FULL, event and pop in the same cycle -> occupancy stays 4, drop_cnt_o unchanged, new entry last in order.
REQ-034 Clear priority: 2 entries, clear_i with simultaneous event and pop -> next cycle EMPTY, drop_cnt_o=0, no entry appears.
REQ-035 Reset and saturation: rst_n low with 3 entries -> rd_valid_o=0 immediately; with DROP_CNT_W=2, 5 drops -> drop_cnt_o=3.
